// File: rtl/mult_share_ctrl_if.sv
// rtl/mult_share_ctrl_if.sv - requester, response and multiplier bundle for mult_share_ctrl
interface mult_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_mcand;
  logic [NREQ*WIDTH-1:0] req_mplier;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  mul_en;
  logic [WIDTH-1:0]      mul_mcand;
  logic [WIDTH-1:0]      mul_mplier;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  busy;

  modport slave (
    input  req_valid, req_mcand, req_mplier, resp_ready, mul_product,
    output req_ready, resp_valid, resp_id, resp_product,
           mul_en, mul_mcand, mul_mplier, busy
  );

  modport master (
    output req_valid, req_mcand, req_mplier, resp_ready, mul_product,
    input  req_ready, resp_valid, resp_id, resp_product,
           mul_en, mul_mcand, mul_mplier, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin sharing of one 3-stage pipelined multiplier with ID tracking
module mult_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input logic          clk,
  input logic          reset,
  mult_share_ctrl_if.slave bus
);
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_made;
  logic           stall;
  int             cand;
  logic [2:0]     v_valid;
  logic [IDW-1:0] v_id [3];

  assign stall      = v_valid[2] && !bus.resp_ready;
  assign bus.mul_en = !stall;

  // Rotating priority: search begins just after the last winner and wraps.
  always_comb begin
    grant_made = 1'b0;
    grant_idx  = '0;
    cand       = 0;
    if (bus.mul_en && !reset) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = (int'(last_grant) + k) % NREQ;
        if (!grant_made && (|((bus.req_valid >> cand) & NREQ'(1)))) begin
          grant_made = 1'b1;
          grant_idx  = IDW'(cand);
        end
      end
    end
  end

  assign bus.req_ready  = grant_made ? (NREQ'(1) << grant_idx) : '0;
  assign bus.mul_mcand  = grant_made ? WIDTH'(bus.req_mcand  >> (int'(grant_idx) * WIDTH)) : '0;
  assign bus.mul_mplier = grant_made ? WIDTH'(bus.req_mplier >> (int'(grant_idx) * WIDTH)) : '0;

  // Tag pipeline advances in lockstep with the multiplier's three registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
      v_valid    <= '0;
      v_id[0]    <= '0;
      v_id[1]    <= '0;
      v_id[2]    <= '0;
    end else if (bus.mul_en) begin
      if (grant_made) begin
        last_grant <= grant_idx;
      end
      v_valid <= {v_valid[1:0], grant_made};
      v_id[0] <= grant_idx;
      v_id[1] <= v_id[0];
      v_id[2] <= v_id[1];
    end
  end

  assign bus.resp_valid   = v_valid[2];
  assign bus.resp_id      = v_id[2];
  assign bus.resp_product = bus.mul_product;
  assign bus.busy         = |v_valid;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - directed self-checking bench for mult_share_ctrl
module tb_mult_share_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   fails;

  mult_share_ctrl_if #(.WIDTH(32), .NREQ(4), .IDW(2)) bus ();

  mult_share_ctrl #(.WIDTH(32), .NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural stand-in for the 3-register pipelined multiplier.
  logic [31:0] m_a, m_b;
  logic [63:0] m_s, m_p;
  always @(posedge clk) begin
    if (reset) begin
      m_a <= '0; m_b <= '0; m_s <= '0; m_p <= '0;
    end else if (bus.mul_en) begin
      m_a <= bus.mul_mcand;
      m_b <= bus.mul_mplier;
      m_s <= {32'b0, m_a} * {32'b0, m_b};
      m_p <= m_s;
    end
  end
  assign bus.mul_product = m_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_mcand[i*32 +: 32]  = a;
    bus.req_mplier[i*32 +: 32] = b;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++;
    if (bus.resp_id !== 2'd0) begin fails++; $display("FAIL reset_resp_id: got %0d want 0", bus.resp_id); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.mul_en !== 1'b1) begin fails++; $display("FAIL reset_mul_en: got %b want 1", bus.mul_en); end
    checks++;
    if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready_hold: got %b want 0000", bus.req_ready); end
    reset = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    set_op(0, 32'hFFFF_FFFF, 32'h2);
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_c0: got %b want 0", bus.busy); end
    checks++;
    if (bus.mul_mcand !== 32'hFFFF_FFFF || bus.mul_mplier !== 32'h2) begin
      fails++; $display("FAIL single_operands: got %h/%h want ffffffff/00000002", bus.mul_mcand, bus.mul_mplier);
    end
    tick();
    bus.req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (bus.busy !== (c <= 3)) begin fails++; $display("FAIL single_busy_c%0d: got %b want %b", c, bus.busy, (c <= 3)); end
      checks++;
      if (bus.resp_valid !== (c == 3)) begin fails++; $display("FAIL single_resp_valid_c%0d: got %b want %b", c, bus.resp_valid, (c == 3)); end
      if (c == 3) begin
        checks++;
        if (bus.resp_id !== 2'd0) begin fails++; $display("FAIL single_resp_id: got %0d want 0", bus.resp_id); end
        checks++;
        if (bus.resp_product !== 64'h1_FFFF_FFFE) begin fails++; $display("FAIL single_product: got %h want 1fffffffe", bus.resp_product); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    apply_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd10);
    for (int c = 0; c < 12; c++) begin
      bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_ready = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checks++;
      if (bus.req_ready !== exp_ready) begin fails++; $display("FAIL rr_grant_c%0d: got %b want %b", c, bus.req_ready, exp_ready); end
      checks++;
      if (bus.resp_valid !== (c >= 3 && c < 11)) begin fails++; $display("FAIL rr_resp_valid_c%0d: got %b", c, bus.resp_valid); end
      if (c >= 3 && c < 11) begin
        checks++;
        if (bus.resp_id !== 2'((c - 3) % 4)) begin fails++; $display("FAIL rr_resp_id_c%0d: got %0d want %0d", c, bus.resp_id, (c - 3) % 4); end
        checks++;
        if (bus.resp_product !== 64'(10 * ((c - 3) % 4 + 1))) begin
          fails++; $display("FAIL rr_product_c%0d: got %0d want %0d", c, bus.resp_product, 10 * ((c - 3) % 4 + 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [63:0] del_prod [$];
    int          del_cyc  [$];
    logic [63:0] exp_prod [4];
    int          exp_cyc  [4];
    exp_prod = '{64'd2000, 64'd3000, 64'd4000, 64'd5000};
    exp_cyc  = '{3, 7, 8, 9};
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      set_op(1, (c <= 3) ? 32'(c + 2) : 32'd99, 32'd1000);
      bus.req_valid  = (c <= 6) ? 4'b0010 : 4'b0000;
      bus.resp_ready = !(c >= 4 && c <= 6);
      #1;
      if (c <= 3) begin
        checks++;
        if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant_c%0d: got %b want 0010", c, bus.req_ready); end
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (bus.mul_en !== 1'b0) begin fails++; $display("FAIL bp_mul_en_c%0d: got %b want 0", c, bus.mul_en); end
        checks++;
        if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL bp_req_ready_c%0d: got %b want 0000", c, bus.req_ready); end
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_product !== 64'd3000) begin
          fails++; $display("FAIL bp_hold_c%0d: got v=%b id=%0d p=%0d want v=1 id=1 p=3000", c, bus.resp_valid, bus.resp_id, bus.resp_product);
        end
      end
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
        del_prod.push_back(bus.resp_product);
        del_cyc.push_back(c);
      end
      tick();
    end
    bus.resp_ready = 1'b1;
    checks++;
    if (del_prod.size() != 4) begin fails++; $display("FAIL bp_count: got %0d want 4", del_prod.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < del_prod.size()) begin
        checks++;
        if (del_prod[k] !== exp_prod[k] || del_cyc[k] != exp_cyc[k]) begin
          fails++; $display("FAIL bp_delivery_%0d: got %0d@c%0d want %0d@c%0d", k, del_prod[k], del_cyc[k], exp_prod[k], exp_cyc[k]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] vt [8];
    logic [3:0] rt [8];
    logic [1:0] id_exp [4];
    logic [63:0] p_exp [4];
    vt = '{4'b1000, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rt = '{4'b1000, 4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    id_exp = '{2'd3, 2'd0, 2'd2, 2'd0};
    p_exp  = '{64'd28, 64'd7, 64'd21, 64'd7};
    apply_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd7);
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = vt[c];
      #1;
      checks++;
      if (bus.req_ready !== rt[c]) begin fails++; $display("FAIL wrap_grant_c%0d: got %b want %b", c, bus.req_ready, rt[c]); end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== id_exp[c-3] || bus.resp_product !== p_exp[c-3]) begin
          fails++; $display("FAIL wrap_resp_c%0d: got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d",
                            c, bus.resp_valid, bus.resp_id, bus.resp_product, id_exp[c-3], p_exp[c-3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_op(2, 32'd5, 32'd5);
    for (int i = 0; i < 4; i++) if (i != 2) set_op(i, 32'd1, 32'd1);
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 4'b0100;
      reset = (c == 2);
      #1;
      checks++;
      if (bus.req_ready !== ((c == 2) ? 4'b0000 : 4'b0100)) begin
        fails++; $display("FAIL mid_grant_c%0d: got %b want %b", c, bus.req_ready, (c == 2) ? 4'b0000 : 4'b0100);
      end
      tick();
    end
    reset = 1'b0;
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after_reset: got %b want 0", bus.busy); end
    for (int c = 3; c < 9; c++) begin
      checks++;
      if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_no_resp_c%0d: got %b want 0", c, bus.resp_valid); end
      tick();
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL mid_next_grant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
  endtask

  task automatic test_corner();
    apply_reset();
    set_op(0, 32'h0, 32'hFFFF_FFFF);
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
      #1;
      if (c == 3) begin
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_product !== 64'h0) begin
          fails++; $display("FAIL corner_zero: got v=%b id=%0d p=%h want v=1 id=0 p=0", bus.resp_valid, bus.resp_id, bus.resp_product);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_product !== 64'hFFFF_FFFE_0000_0001) begin
          fails++; $display("FAIL corner_max: got v=%b id=%0d p=%h want v=1 id=1 p=fffffffe00000001", bus.resp_valid, bus.resp_id, bus.resp_product);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL corner_idle: got %b want 0", bus.resp_valid); end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    bus.req_valid  = '0;
    bus.req_mcand  = '0;
    bus.req_mplier = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_stall();
    test_wrap();
    test_reset_midflight();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencer and arbiter that shares one `pipelined_multiplier` instance (WIDTH=32) among NREQ requesters. Requesters are served round-robin, at most one operation issued per cycle. The block tracks the requester ID of each in-flight operation through the 3-register multiplier pipeline. It returns each product with the ID of its requester, and freezes the whole pipeline through the multiplier's `en` when the response consumer back-pressures.

## Interface
Parameters:
- WIDTH, 32, operand width; must equal the multiplier's WIDTH (32).
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester-ID width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has an operation pending.
- req_mcand  in  NREQ*WIDTH  packed multiplicands; requester i at [i*WIDTH +: WIDTH].
- req_mplier  in  NREQ*WIDTH  packed multipliers; same packing as req_mcand.
- req_ready  out  NREQ  one-hot grant; requester i's operation is accepted in a cycle where req_valid[i] && req_ready[i].
- resp_valid  out  1  resp_product and resp_id are valid.
- resp_ready  in  1  consumer accepts the response this cycle.
- resp_id  out  IDW  requester index for the current response.
- resp_product  out  2*WIDTH  product; equals mul_product.
- mul_en  out  1  drives the multiplier `en`.
- mul_mcand  out  WIDTH  drives the multiplier `mcand`.
- mul_mplier  out  WIDTH  drives the multiplier `mplier`.
- mul_product  in  2*WIDTH  multiplier `product`.
- busy  out  1  at least one operation is in flight or a response is being presented.

## Operation
- stall = resp_valid && !resp_ready; mul_en = !stall (combinational).
- Arbitration:
  - Runs only when mul_en=1. When stalled, req_ready = 0.
  - Search starts at (last_grant+1) mod NREQ and wraps. The first requester with req_valid=1 gets req_ready=1.
  - last_grant updates to the winner on that edge. When no request is granted, last_grant is unchanged.
  - Issue happens only when a grant is made; the grant is the sole accept condition.
- Operand mux: when a grant is made, mul_mcand and mul_mplier are the granted requester's operands. Otherwise both are 0 (a bubble).
- Tracking pipeline:
  - Three stages v0..v2 of {valid, id}, mirroring the multiplier's input, stage and output registers.
  - When mul_en=1, on each edge: v0 <= {grant_made, grant_idx}, v1 <= v0, v2 <= v1.
  - When mul_en=0, all three stages hold.
- Response outputs: resp_valid = v2.valid, resp_id = v2.id, resp_product = mul_product.
- busy = v0.valid | v1.valid | v2.valid.
- Arithmetic: unsigned product, full 2*WIDTH width, no truncation; computed by the multiplier.
- Reset:
  - Clears v0..v2.valid and v0..v2.id to 0.
  - Sets last_grant = NREQ-1, so requester 0 has first priority.
  - Any operation in flight is discarded; no response is produced for it.
  - The multiplier shares the same reset net.
- Requester IDs >= NREQ never appear on resp_id.

## Timing
- Reset values: req_ready = 0 while reset is high; resp_valid=0, resp_id=0, busy=0. mul_en=1 after reset, since resp_valid=0.
- Latency:
  - Operation accepted in cycle c → resp_valid=1 with its product in cycle c+3 when no stall occurs.
  - Each stall cycle adds exactly one cycle of latency.
- Throughput: one issue and one response per cycle when resp_ready is held at 1.
- Stall rules:
  - While resp_valid && !resp_ready: resp_id and resp_product hold stable, no new grant is made, and the multiplier does not advance.
  - Release is the same cycle resp_ready returns to 1: that edge pops the response and accepts one new request.
- Simultaneous requests: grants follow rotating priority. With all NREQ requesters continuously valid, grant order is 0,1,…,NREQ-1,0,… with no requester served twice before the others are served once.
- An idle pipeline issues bubbles; bubbles never raise resp_valid.

## Test plan
- Single op: after reset, req_valid=0001, mcand=0xFFFF_FFFF, mplier=0x2 for 1 cycle → req_ready[0]=1 in cycle 0; resp_valid=1 in cycle 3 with resp_id=0 and resp_product=0x1_FFFF_FFFE; busy high in cycles 1-3.
- Round-robin fairness: all 4 requesters held valid with requester i using mcand=i+1, mplier=10 → grants 0,1,2,3,0,… one per cycle; responses in order with resp_id 0,1,2,3 and products 10,20,30,40 starting at cycle 3.
- Backpressure: stream of 4 ops, resp_ready=0 for cycles 4-6 → mul_en=0 and req_ready=0 in those cycles, resp_product held; after release all 4 results delivered, none lost or duplicated.
- Wrap-around priority: last_grant=3, requesters 0 and 2 valid → requester 0 granted first, then 2.
- Reset mid-flight: issue 3 ops, assert reset in cycle 2 → in the cycle after reset, resp_valid=0 and busy=0; none of the 3 ops produces a response; the next grant goes to requester 0.
- Corner operands: 0x0 × 0xFFFF_FFFF → 0; 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001.
